// File: rtl/i2s_audio_tx_if.sv
// i2s_audio_tx_if
// Groups the sample-side inputs and the I2S/strobe outputs of i2s_audio_tx.
//   ena, mute            run request and mute, sampled at frame start
//   audio_l, audio_r     16-bit two's complement stereo pair
//   i2s_bclk/lrclk/data  Philips I2S stream toward the DAC
//   sample_strobe        one-clk pulse on the latch cycle
// slave  : the transmitter (consumes samples, drives the I2S pins)
// master : the sample source / observer
interface i2s_audio_tx_if;
    logic        ena;
    logic        mute;
    logic [15:0] audio_l;
    logic [15:0] audio_r;
    logic        i2s_bclk;
    logic        i2s_lrclk;
    logic        i2s_data;
    logic        sample_strobe;

    modport slave (
        input  ena, mute, audio_l, audio_r,
        output i2s_bclk, i2s_lrclk, i2s_data, sample_strobe
    );

    modport master (
        output ena, mute, audio_l, audio_r,
        input  i2s_bclk, i2s_lrclk, i2s_data, sample_strobe
    );
endinterface

// File: rtl/i2s_audio_tx.sv
// i2s_audio_tx
// Serialises a 16-bit stereo pair into a Philips I2S stream with 64 BCLK per
// frame (32-bit slots). BCLK is clk divided by 2*CLKDIV; both channels are
// latched together once per frame.
//   CLKDIV    clk cycles per BCLK half-period (2..255)
//   clk       system clock
//   reset_in  asynchronous active-low reset
//   bus       i2s_audio_tx_if.slave (ena, mute, audio_l/r in; I2S pins and
//             sample_strobe out)
//
// state | meaning
// IDLE  | outputs held low, waiting for ena
// RUN   | dividing clk, shifting out the current frame
module i2s_audio_tx #(
    parameter int unsigned CLKDIV = 18
) (
    input  logic           clk,
    input  logic           reset_in,
    i2s_audio_tx_if.slave  bus
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLKDIV - 1);
    localparam logic [5:0] CNT_LAST = 6'd63;

    state_t      state_q,  state_d;
    logic [7:0]  div_q,    div_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0] hold_l_q, hold_l_d;
    logic [15:0] hold_r_q, hold_r_d;
    logic        bclk_q,   bclk_d;
    logic        lrclk_q,  lrclk_d;
    logic        data_q,   data_d;
    logic        strobe_q, strobe_d;

    logic        frame_start;
    logic [5:0]  n_next;
    logic [4:0]  k_next;
    logic [3:0]  bit_idx;
    logic [15:0] slot_sample;
    logic        next_bit;

    // Data for the position the counter is about to move to. k=1..16 carries
    // the sample MSB first; k=0 and k=17..31 are padding.
    always_comb begin
        n_next      = bit_cnt_q + 6'd1;
        k_next      = n_next[4:0];
        bit_idx     = 4'(5'd16 - k_next);
        slot_sample = n_next[5] ? hold_r_q : hold_l_q;
        next_bit    = 1'b0;
        if ((k_next >= 5'd1) && (k_next <= 5'd16)) begin
            next_bit = slot_sample[bit_idx];
        end
    end

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        bit_cnt_d   = bit_cnt_q;
        hold_l_d    = hold_l_q;
        hold_r_d    = hold_r_q;
        bclk_d      = bclk_q;
        lrclk_d     = lrclk_q;
        data_d      = data_q;
        strobe_d    = 1'b0;
        frame_start = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.ena) begin
                    frame_start = 1'b1;
                end
            end
            RUN: begin
                if (div_q == DIV_LAST) begin
                    div_d  = 8'd0;
                    bclk_d = ~bclk_q;
                    // bclk_q high here means this wrap is a falling event
                    if (bclk_q) begin
                        if (bit_cnt_q != CNT_LAST) begin
                            bit_cnt_d = n_next;
                            lrclk_d   = n_next[5];
                            data_d    = next_bit;
                        end else if (bus.ena) begin
                            frame_start = 1'b1;
                        end else begin
                            state_d   = IDLE;
                            bit_cnt_d = CNT_LAST;
                            lrclk_d   = 1'b0;
                            data_d    = 1'b0;
                        end
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Inputs are only looked at here, so mid-frame changes never reach
        // the frame in progress.
        if (frame_start) begin
            state_d   = RUN;
            div_d     = 8'd0;
            bit_cnt_d = 6'd0;
            hold_l_d  = bus.mute ? 16'd0 : bus.audio_l;
            hold_r_d  = bus.mute ? 16'd0 : bus.audio_r;
            strobe_d  = 1'b1;
            bclk_d    = 1'b0;
            lrclk_d   = 1'b0;
            data_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            state_q   <= IDLE;
            div_q     <= 8'd0;
            bit_cnt_q <= CNT_LAST;
            hold_l_q  <= 16'd0;
            hold_r_q  <= 16'd0;
            bclk_q    <= 1'b0;
            lrclk_q   <= 1'b0;
            data_q    <= 1'b0;
            strobe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bit_cnt_q <= bit_cnt_d;
            hold_l_q  <= hold_l_d;
            hold_r_q  <= hold_r_d;
            bclk_q    <= bclk_d;
            lrclk_q   <= lrclk_d;
            data_q    <= data_d;
            strobe_q  <= strobe_d;
        end
    end

    assign bus.i2s_bclk      = bclk_q;
    assign bus.i2s_lrclk     = lrclk_q;
    assign bus.i2s_data      = data_q;
    assign bus.sample_strobe = strobe_q;

endmodule
